sub12bit_ns: RTL and testbench
==============================

Name: sub12bit_ns

Overview:
- Nibble-serial 12-bit subtractor for the Extended DLX TinyML datapath; the inverse direction of the ripple-nibble adder.
- Computes DIFF = A - B - Bin, one 4-bit nibble per clock, LSB nibble first, with the borrow rippled between cycles.
- Provides a start/in_ready/done handshake plus borrow-out and signed-overflow flags, so the ALU can share one small nibble subtract cell over multiple cycles.

Parameters:
- WIDTH, 12, operand/result width; must be a multiple of NIB.
- NIB, 4, bits processed per cycle; NSTEP = WIDTH/NIB (3 by default).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when in_ready=1.
- in_ready  output  1  block can accept start (IDLE or DONE).
- A  input  WIDTH  minuend; captured on accepted start.
- B  input  WIDTH  subtrahend; captured on accepted start.
- Bin  input  1  borrow-in; captured on accepted start.
- DIFF  output  WIDTH  result; registered; updated only on completion.
- Bout  output  1  final borrow (1 when A < B+Bin, unsigned).
- OVF  output  1  signed overflow: (A[MSB]!=B[MSB]) && (DIFF[MSB]!=A[MSB]).
- busy  output  1  high in RUN.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Clocking: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, busy=0, done=0, DIFF=0, Bout=0, OVF=0, step counter=0, internal operand/borrow registers=0.
- States:
  - IDLE: in_ready=1. start=1 -> capture A, B, Bin into internal registers, clear the counter, go to RUN.
  - RUN: busy=1, in_ready=0. Each edge computes nibble k = A[k] - B[k] - borrow, writes it into the internal result register, updates borrow, and increments k. On the edge that processes k=NSTEP-1: load DIFF, Bout and OVF from the completed result, go to DONE.
  - DONE: done=1 for exactly one cycle; in_ready=1. start=1 -> capture new operands and go to RUN (back-to-back). Otherwise go to IDLE.
- start is ignored while in RUN; captured operands must not change.
- Latency: start accepted at edge 0; nibbles processed at edges 1..NSTEP; done=1 in the cycle after edge NSTEP (cycle 3 by default).
- Throughput: one result per NSTEP+1 cycles with back-to-back starts.
- DIFF, Bout and OVF hold their last values through IDLE and any following RUN until the next completion. They never show partial nibbles.
- Arithmetic: result is modulo 2^WIDTH; Bout is the borrow out of the MSB nibble; the OVF formula uses the full-width result.
- Reset mid-RUN: the operation is abandoned, all outputs return to reset values, and no done pulse is produced.
- reset and start in the same cycle: reset wins.

Test Plan:
- A=0x5A3, B=0x0F4, Bin=0, single start -> done exactly 3 cycles later with DIFF=0x4AF, Bout=0, OVF=0; busy high for exactly 3 cycles.
- A=0x800, B=0x001, Bin=0 -> DIFF=0x7FF, Bout=0, OVF=1.
- A=0x000, B=0x001, Bin=0 -> DIFF=0xFFF, Bout=1, OVF=0. Then A=0x123, B=0x123, Bin=1 -> DIFF=0xFFF, Bout=1, OVF=0.
- Pulse start with A=0x111, B=0x001, then pulse start again one cycle later with A=0xFFF, B=0xFFF -> second start ignored; result DIFF=0x110; DIFF stays 0x000 until the done cycle.
- Assert start again in the done cycle with A=0x010, B=0x020 -> no IDLE gap; second done 4 cycles after the first with DIFF=0xFFF0-truncated=0xFF0, Bout=1.
- Assert reset during the 2nd RUN cycle -> next cycle in_ready=1, busy=0, DIFF=0, and done never pulses. A subsequent start with A=0x002, B=0x001 -> DIFF=0x001.

Source files
------------

// File: rtl/sub12bit_ns.sv
// Nibble-serial subtractor: DIFF = A - B - Bin, one NIB-bit slice per clock,
// LSB slice first, with the borrow carried between cycles. DIFF/Bout/OVF only
// change on completion, so consumers never see a partially built result.
module sub12bit_ns #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned NIB   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] DIFF,
    output logic             Bout,
    output logic             OVF,
    output logic             busy,
    output logic             done
);

    localparam int unsigned NSTEP = WIDTH / NIB;
    localparam int unsigned CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state, state_next;
    logic [CW-1:0]    cnt, cnt_next;
    logic [WIDTH-1:0] a_op, a_next;
    logic [WIDTH-1:0] b_op, b_next;
    logic [WIDTH-1:0] res, res_next;
    logic             brw, brw_next;
    logic [WIDTH-1:0] diff_next;
    logic             bout_next;
    logic             ovf_next;

    // Current slice arithmetic and the result with that slice merged in
    logic [NIB-1:0]   nib_a, nib_b;
    logic [NIB:0]     nib_sub;
    logic [31:0]      shamt;
    logic [WIDTH-1:0] res_upd;
    logic             last_step;

    // Slice select, slice subtract and merge into the partial result
    always_comb begin
        shamt     = 32'(cnt) * NIB;
        nib_a     = NIB'(a_op >> shamt);
        nib_b     = NIB'(b_op >> shamt);
        // One extra bit catches the borrow: it goes high when the slice underflows
        nib_sub   = {1'b0, nib_a} - {1'b0, nib_b} - {{NIB{1'b0}}, brw};
        res_upd   = (res & ~(WIDTH'({NIB{1'b1}}) << shamt))
                  | (WIDTH'(nib_sub[NIB-1:0]) << shamt);
        last_step = (cnt == CW'(NSTEP - 1));
    end

    // Next-state and datapath update; handshake outputs decoded from state
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        a_next     = a_op;
        b_next     = b_op;
        res_next   = res;
        brw_next   = brw;
        diff_next  = DIFF;
        bout_next  = Bout;
        ovf_next   = OVF;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            StIdle, StDone: begin
                in_ready = 1'b1;
                done     = (state == StDone);
                if (start) begin
                    a_next     = A;
                    b_next     = B;
                    brw_next   = Bin;
                    res_next   = '0;
                    cnt_next   = '0;
                    state_next = StRun;
                end else begin
                    state_next = StIdle;
                end
            end
            StRun: begin
                busy     = 1'b1;
                res_next = res_upd;
                brw_next = nib_sub[NIB];
                cnt_next = cnt + CW'(1);
                if (last_step) begin
                    diff_next  = res_upd;
                    bout_next  = nib_sub[NIB];
                    ovf_next   = (a_op[WIDTH-1] != b_op[WIDTH-1]) &&
                                 (res_upd[WIDTH-1] != a_op[WIDTH-1]);
                    cnt_next   = '0;
                    state_next = StDone;
                end
            end
            default: state_next = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= StIdle;
            cnt   <= '0;
            a_op  <= '0;
            b_op  <= '0;
            res   <= '0;
            brw   <= 1'b0;
            DIFF  <= '0;
            Bout  <= 1'b0;
            OVF   <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            a_op  <= a_next;
            b_op  <= b_next;
            res   <= res_next;
            brw   <= brw_next;
            DIFF  <= diff_next;
            Bout  <= bout_next;
            OVF   <= ovf_next;
        end
    end

endmodule

// File: tb/tb_sub12bit_ns.sv
// Directed bench for sub12bit_ns with a queue of expected results.
module tb_sub12bit_ns;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        in_ready;
    logic [11:0] A = '0;
    logic [11:0] B = '0;
    logic        Bin = 1'b0;
    logic [11:0] DIFF;
    logic        Bout, OVF, busy, done;

    sub12bit_ns #(.WIDTH(12), .NIB(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .Bin      (Bin),
        .DIFF     (DIFF),
        .Bout     (Bout),
        .OVF      (OVF),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] diff;
        logic        bout;
        logic        ovf;
    } exp_t;

    exp_t        sb[$];
    int          nvec = 0;
    int          nmis = 0;
    logic [11:0] held_diff = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [11:0] a, input logic [11:0] b, input logic bin);
        exp_t e;
        e.diff = a - b - {11'd0, bin};
        e.bout = (int'(a) < int'(b) + int'(bin));
        e.ovf  = (a[11] != b[11]) && (e.diff[11] != a[11]);
        return e;
    endfunction

    // Drive one accepted start and push its expected result
    task automatic issue(input logic [11:0] a, input logic [11:0] b, input logic bin);
        A     = a;
        B     = b;
        Bin   = bin;
        start = 1'b1;
        sb.push_back(model(a, b, bin));
        tick();
        start = 1'b0;
    endtask

    // Wait (bounded) for done; check latency, busy span, held DIFF and the result
    task automatic wait_done(input string tag, input int lat, input int nbusy);
        int   n  = 0;
        int   nb = 0;
        exp_t e;
        while (done !== 1'b1 && n < 20) begin
            if (busy === 1'b1) nb++;
            check({tag, "_hold"}, 32'(DIFF), 32'(held_diff));
            tick();
            n++;
        end
        check({tag, "_lat"}, n, lat);
        check({tag, "_busy"}, nb, nbusy);
        check({tag, "_sb"}, 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_diff"}, 32'(DIFF), 32'(e.diff));
            check({tag, "_bout"}, 32'(Bout), 32'(e.bout));
            check({tag, "_ovf"}, 32'(OVF), 32'(e.ovf));
            check({tag, "_rdy"}, 32'(in_ready), 1);
            held_diff = e.diff;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        held_diff = '0;
        sb.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        do_reset();
        check("rst_rdy", 32'(in_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_diff", 32'(DIFF), 0);
        check("rst_bout", 32'(Bout), 0);
        check("rst_ovf", 32'(OVF), 0);

        // Basic operation and latency
        issue(12'h5A3, 12'h0F4, 1'b0);
        check("t1_busy0", 32'(busy), 1);
        check("t1_rdy0", 32'(in_ready), 0);
        wait_done("t1", 3, 3);
        check("t1_abs", 32'(DIFF), 32'h4AF);
        tick();
        check("t1_pulse", 32'(done), 0);

        // Signed overflow
        issue(12'h800, 12'h001, 1'b0);
        wait_done("t2", 3, 3);
        check("t2_ovf_abs", 32'(OVF), 1);
        tick();

        // Borrow out, and borrow-in on equal operands
        issue(12'h000, 12'h001, 1'b0);
        wait_done("t3a", 3, 3);
        check("t3a_bout_abs", 32'(Bout), 1);
        tick();
        issue(12'h123, 12'h123, 1'b1);
        wait_done("t3b", 3, 3);
        check("t3b_diff_abs", 32'(DIFF), 32'hFFF);
        tick();

        // Start during RUN ignored; DIFF held at 0 until done
        do_reset();
        issue(12'h111, 12'h001, 1'b0);
        A     = 12'hFFF;
        B     = 12'hFFF;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t4", 2, 2);
        check("t4_diff_abs", 32'(DIFF), 32'h110);

        // Back-to-back start in the done cycle
        issue(12'h010, 12'h020, 1'b0);
        wait_done("t5", 3, 3);
        check("t5_diff_abs", 32'(DIFF), 32'hFF0);
        tick();

        // Reset in the second RUN cycle abandons the operation
        issue(12'h7AB, 12'h123, 1'b0);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        held_diff = '0;
        check("t6_rdy", 32'(in_ready), 1);
        check("t6_busy", 32'(busy), 0);
        check("t6_diff", 32'(DIFF), 0);
        check("t6_bout", 32'(Bout), 0);
        check("t6_ovf", 32'(OVF), 0);
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1) saw_done = 1'b1;
            tick();
        end
        check("t6_nodone", 32'(saw_done), 0);
        issue(12'h002, 12'h001, 1'b0);
        wait_done("t6", 3, 3);
        tick();

        // Reset wins over a simultaneous start
        A     = 12'h0AA;
        B     = 12'h055;
        start = 1'b1;
        reset = 1'b1;
        tick();
        start = 1'b0;
        reset = 1'b0;
        check("t7_busy", 32'(busy), 0);
        check("t7_rdy", 32'(in_ready), 1);
        tick();
        check("t7_done", 32'(done), 0);
        check("t7_diff", 32'(DIFF), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
